// File: rtl/aurora_pkg.sv
// Shared types for the data-memory port arbiter: FSM states, access owner
// and the largest memory read latency the arbiter supports.
package aurora_pkg;

  localparam int DMEM_LAT_MAX = 4;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_DONE
  } dmem_state_e;

  typedef enum logic {
    OWN_PIPE,
    OWN_HOST
  } dmem_owner_e;

endpackage

// File: rtl/dmem_starve_ctr.sv
// Host starvation counter: counts pipe grants taken while the host waits and
// flags when the limit is reached. Only built with DMEM_ARB_FAIRNESS_EN.
`ifdef DMEM_ARB_FAIRNESS_EN
module dmem_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic hit_o
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear wins over increment; the count saturates at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CW'(STARVE_MAX))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == CW'(STARVE_MAX));

endmodule
`endif

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the MEM stage and a host port.
// Build option DMEM_ARB_FAIRNESS_EN bounds how long the host can be starved.
module dmem_port_arbiter
  import aurora_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 8,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pipe_req_i,
  input  logic              pipe_we_i,
  input  logic [63:0]       pipe_addr_i,
  input  logic [DATA_W-1:0] pipe_wdata_i,
  output logic [DATA_W-1:0] pipe_rdata_o,
  output logic              pipe_stall_o,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [63:0]       host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_gnt_o,
  output logic [DATA_W-1:0] host_rdata_o,
  output logic              host_rvalid_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int CNT_W = $clog2(DMEM_LAT_MAX);

  dmem_state_e       state_q, state_d;
  dmem_owner_e       owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] pipe_rdata_q, pipe_rdata_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

  logic idle_ok;
  logic host_first;
  logic pipe_gnt;
  logic host_gnt;

  // Gating with rst_i keeps every strobe quiet while reset is held.
  assign idle_ok = rst_i && (state_q == IDLE);

`ifdef DMEM_ARB_FAIRNESS_EN
  logic starve_hit;

  dmem_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (pipe_gnt & host_req_i),
    .clr_i (host_gnt | ~host_req_i),
    .hit_o (starve_hit)
  );

  assign host_first = starve_hit & host_req_i;
`else
  localparam int unused_starve_max = STARVE_MAX;

  assign host_first = 1'b0;
`endif

  assign pipe_gnt = idle_ok & pipe_req_i & ~host_first;
  assign host_gnt = idle_ok & host_req_i & (host_first | ~pipe_req_i);

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (pipe_gnt) begin
      mem_en_o    = 1'b1;
      mem_we_o    = pipe_we_i;
      mem_addr_o  = pipe_addr_i[ADDR_W+2:3];
      mem_wdata_o = pipe_wdata_i;
    end else if (host_gnt) begin
      mem_en_o    = 1'b1;
      mem_we_o    = host_we_i;
      mem_addr_o  = host_addr_i[ADDR_W+2:3];
      mem_wdata_o = host_wdata_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    pipe_rdata_d = pipe_rdata_q;
    host_rdata_d = host_rdata_q;
    unique case (state_q)
      IDLE: begin
        if ((pipe_gnt && !pipe_we_i) || (host_gnt && !host_we_i)) begin
          state_d = RD_WAIT;
          owner_d = pipe_gnt ? OWN_PIPE : OWN_HOST;
          cnt_d   = CNT_W'(MEM_LAT - 1);
        end
      end
      RD_WAIT: begin
        // Count reaching zero marks the cycle the memory data is valid.
        if (cnt_q == '0) begin
          state_d = RD_DONE;
          if (owner_q == OWN_PIPE) begin
            pipe_rdata_d = mem_rdata_i;
          end else begin
            host_rdata_d = mem_rdata_i;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      owner_q      <= OWN_PIPE;
      cnt_q        <= '0;
      pipe_rdata_q <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      pipe_rdata_q <= pipe_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign pipe_stall_o  = pipe_req_i
                       & ~(pipe_gnt & pipe_we_i)
                       & ~((state_q == RD_DONE) & (owner_q == OWN_PIPE));
  assign host_gnt_o    = host_gnt;
  assign host_rvalid_o = (state_q == RD_DONE) && (owner_q == OWN_HOST);
  assign pipe_rdata_o  = pipe_rdata_q;
  assign host_rdata_o  = host_rdata_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{pipe_addr_i[63:ADDR_W+3], pipe_addr_i[2:0],
                              host_addr_i[63:ADDR_W+3], host_addr_i[2:0]};

endmodule
